fetch_sequencer: RTL

//  - Program-counter controller for the single-cycle ARM datapath; owns PC, drives Instruction_Memory Address.
//  - Decodes B/CBNZ from the fetched word, computes next PC, and gates datapath commits.
//  - Detects self-branch halt (B #0) and out-of-range fetch (fault).
//  - Sits between Instruction_Memory and the register file / ALU / data-memory datapath.

---
 rtl/arm_isa_pkg.sv | 24 ++
 rtl/branch_target_unit.sv | 49 ++++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/arm_isa_pkg.sv
// Shared ARM-subset ISA constants and sequencer state type for the fetch path.
package arm_isa_pkg;

   localparam logic [10:0] OP_AND  = 11'h450;
   localparam logic [10:0] OP_ADD  = 11'h458;
   localparam logic [10:0] OP_ORR  = 11'h550;
   localparam logic [10:0] OP_SUB  = 11'h658;
   localparam logic [10:0] OP_STUR = 11'h7C0;
   localparam logic [10:0] OP_LDUR = 11'h7C2;
   localparam logic [10:0] OP_MOVK = 11'h794;
   localparam logic [10:0] OP_CBNZ = 11'h5A0;
   localparam logic [10:0] OP_B    = 11'h0A0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } seq_state_t;

   function automatic logic [10:0] opcode_of(input logic [31:0] instr);
      return instr[31:21];
   endfunction

endpackage

// File: rtl/branch_target_unit.sv
// Combinational next-PC computation for B / CBNZ / sequential fetch; holds no state.
module branch_target_unit
   import arm_isa_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
) (
   input  logic [INSTR_W-1:0] instr,
   input  logic [ADDR_W-1:0]  pc,
   input  logic               reg_zero,
   output logic [ADDR_W-1:0]  next_pc,
   output logic               is_branch,
   output logic               taken,
   output logic               is_halt
);

   logic [ADDR_W-1:0] off_s;

   // decode the opcode field and select the sign-extended word offset
   always_comb begin
      off_s     = {{(ADDR_W-1){1'b0}}, 1'b1};
      is_branch = 1'b0;
      taken     = 1'b0;
      is_halt   = 1'b0;
      case (opcode_of(instr))
         OP_B: begin
            is_branch = 1'b1;
            taken     = 1'b1;
            off_s     = {{(ADDR_W-21){instr[20]}}, instr[20:0]};
            is_halt   = (instr[20:0] == 21'd0);
         end
         OP_CBNZ: begin
            is_branch = 1'b1;
            if (!reg_zero) begin
               taken = 1'b1;
               off_s = {{(ADDR_W-16){instr[20]}}, instr[20:5]};
            end else begin
               taken = 1'b0;
            end
         end
         default: begin
            is_branch = 1'b0;
         end
      endcase
      // modulo 2^ADDR_W: a negative target wraps high and is caught as out of range
      next_pc = pc + off_s;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner for the single-cycle datapath: fetch sequencing, halt on B #0, fault on out-of-range PC.
// Optional retired-instruction counter enabled by macro FETCH_SEQ_PERF_CNT_EN.
module fetch_sequencer
   import arm_isa_pkg::*;
#(
   parameter int ADDR_W     = 64,
   parameter int INSTR_W    = 32,
   parameter int IMEM_DEPTH = 64
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               Start,
   input  logic               StallReq,
   input  logic [INSTR_W-1:0] Instr,
   input  logic               RegZero,
   output logic [ADDR_W-1:0]  PC,
   output logic [4:0]         CbRegSel,
   output logic               InstrValid,
   output logic               BranchTaken,
   output logic               Halted,
   output logic               Fault
`ifdef FETCH_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]        RetireCount
`endif
);

   seq_state_t        state_r;
   logic [ADDR_W-1:0] pc_r;
   logic              halted_r;
   logic              fault_r;
   logic [ADDR_W-1:0] next_pc_s;
   logic              is_branch_s;
   logic              taken_s;
   logic              is_halt_s;
   logic              out_of_range_s;

   branch_target_unit #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_btu (
      .instr     (Instr),
      .pc        (pc_r),
      .reg_zero  (RegZero),
      .next_pc   (next_pc_s),
      .is_branch (is_branch_s),
      .taken     (taken_s),
      .is_halt   (is_halt_s)
   );

   // commit qualifiers stay combinational so a reset mid-cycle kills the write enable at once
   assign InstrValid     = (state_r == RUN) & ~StallReq;
   assign BranchTaken    = InstrValid & is_branch_s & taken_s;
   assign CbRegSel       = Instr[4:0];
   assign out_of_range_s = (next_pc_s >= ADDR_W'(IMEM_DEPTH));
   assign PC             = pc_r;
   assign Halted         = halted_r;
   assign Fault          = fault_r;

   // sequencer FSM with PC, halt and fault registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r  <= IDLE;
         pc_r     <= {ADDR_W{1'b0}};
         halted_r <= 1'b0;
         fault_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE, HALT: begin
               if (Start) begin
                  state_r  <= RUN;
                  pc_r     <= {ADDR_W{1'b0}};
                  halted_r <= 1'b0;
                  fault_r  <= 1'b0;
               end
            end
            RUN: begin
               if (!StallReq) begin
                  if (is_halt_s) begin
                     state_r  <= HALT;
                     halted_r <= 1'b1;
                  end else if (out_of_range_s) begin
                     state_r  <= HALT;
                     halted_r <= 1'b1;
                     fault_r  <= 1'b1;
                  end else begin
                     pc_r <= next_pc_s;
                  end
               end
            end
            default: begin
               state_r  <= IDLE;
               pc_r     <= {ADDR_W{1'b0}};
               halted_r <= 1'b0;
               fault_r  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_SEQ_PERF_CNT_EN
   logic [31:0] retire_r;

   // saturating count of committed instructions, restarted with each program launch
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         retire_r <= 32'd0;
      end else if ((state_r != RUN) && Start) begin
         retire_r <= 32'd0;
      end else if (InstrValid && (retire_r != 32'hFFFF_FFFF)) begin
         retire_r <= retire_r + 32'd1;
      end
   end

   assign RetireCount = retire_r;
`endif

endmodule
